// File: rtl/cpu_pkg.sv
// Shared encodings for the UART programming sequencer: FSM states and frame target codes.
// Pure definitions; no timing or flow-control behaviour of its own.
package cpu_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HDR_TGT   = 3'd1;
    localparam logic [2:0] ST_HDR_CNT_L = 3'd2;
    localparam logic [2:0] ST_HDR_CNT_H = 3'd3;
    localparam logic [2:0] ST_PAYLOAD   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    localparam logic [7:0] TGT_IMEM = 8'h00;
    localparam logic [7:0] TGT_DMEM = 8'h01;
    localparam logic [7:0] TGT_END  = 8'hFF;

    function automatic logic is_mem_tgt(input logic [7:0] b);
        return (b == TGT_IMEM) || (b == TGT_DMEM);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs four little-endian bytes into a 32-bit word; word_vld fires combinationally with the 4th byte.
// No backpressure: every enabled byte strobe is consumed; synchronous clear has priority.
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_vld
);

    logic [1:0]  r_idx;
    // Only bytes 0..2 are stored; byte 3 is taken straight off the input.
    logic [23:0] r_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clr) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_en && i_vld) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_shift[7:0]   <= i_byte;
                2'd1:    r_shift[15:8]  <= i_byte;
                2'd2:    r_shift[23:16] <= i_byte;
                default: r_shift        <= r_shift;
            endcase
        end
    end

    assign o_word     = {i_byte, r_shift};
    assign o_word_vld = i_en && i_vld && (r_idx == 2'd3);

endmodule

// File: rtl/uart_prog_ctrl.sv
// UART programming sequencer: holds the CPU in reset, parses framed bytes, writes words to imem/dmem.
// Write strobe one edge after the 4th payload byte; no backpressure, bytes are accepted as they arrive.
module uart_prog_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_prog,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              err
);

    localparam int                TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;

    logic [2:0]        r_state;
    logic              r_tgt;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_off;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_wen;
    logic [ADDR_W:0]   r_adr;
    logic [31:0]       r_dat;
    logic              r_done;
    logic              r_err;

    logic [2:0]        w_state_nxt;
    logic [15:0]       w_count;
    logic              w_timing;
    logic              w_tmo_hit;
    logic              w_last;
    logic              w_start_ok;
    logic              w_asm_clr;
    logic [31:0]       w_word;
    logic              w_word_vld;

    assign w_count    = {rx_byte, r_cnt[7:0]};
    assign w_timing   = (r_state == ST_HDR_CNT_L) || (r_state == ST_HDR_CNT_H) ||
                        (r_state == ST_PAYLOAD);
    assign w_tmo_hit  = w_timing && !rx_valid && (r_tmo == TMO_MAX);
    assign w_last     = (32'(r_off) + 32'd1) == 32'(r_cnt);
    assign w_start_ok = start_prog && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
    // A half-built word must never leak into the next section or session.
    assign w_asm_clr  = (w_state_nxt != r_state) || w_tmo_hit;

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_asm_clr),
        .i_en       (r_state == ST_PAYLOAD),
        .i_vld      (rx_valid),
        .i_byte     (rx_byte),
        .o_word     (w_word),
        .o_word_vld (w_word_vld)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_prog) w_state_nxt = ST_HDR_TGT;
            end
            ST_HDR_TGT: begin
                if (rx_valid) begin
                    if (is_mem_tgt(rx_byte))     w_state_nxt = ST_HDR_CNT_L;
                    else if (rx_byte == TGT_END) w_state_nxt = ST_DONE;
                    else                         w_state_nxt = ST_ERROR;
                end
            end
            ST_HDR_CNT_L: begin
                if (rx_valid) w_state_nxt = ST_HDR_CNT_H;
            end
            ST_HDR_CNT_H: begin
                if (rx_valid) begin
                    if (w_count == 16'd0)                w_state_nxt = ST_HDR_TGT;
                    else if (32'(w_count) > MAX_WORDS)   w_state_nxt = ST_ERROR;
                    else                                 w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_word_vld && w_last) w_state_nxt = ST_HDR_TGT;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_ERROR: begin
                if (start_prog) w_state_nxt = ST_HDR_TGT;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_tmo_hit) w_state_nxt = ST_ERROR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tgt   <= 1'b0;
            r_cnt   <= 16'd0;
            r_off   <= '0;
            r_tmo   <= '0;
            r_wen   <= 1'b0;
            r_adr   <= '0;
            r_dat   <= 32'd0;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wen   <= 1'b0;

            if (r_state == ST_HDR_TGT && rx_valid && is_mem_tgt(rx_byte))
                r_tgt <= rx_byte[0];
            if (r_state == ST_HDR_CNT_L && rx_valid)
                r_cnt[7:0] <= rx_byte;
            if (r_state == ST_HDR_CNT_H && rx_valid) begin
                r_cnt <= w_count;
                r_off <= '0;
            end

            if (w_word_vld) begin
                r_wen <= 1'b1;
                r_adr <= {r_tgt, r_off};
                r_dat <= w_word;
                r_off <= r_off + ADDR_W'(1);
            end

            // Idle-gap counter restarts on every byte and every state change.
            if (w_timing && !rx_valid && (w_state_nxt == r_state))
                r_tmo <= r_tmo + TMO_W'(1);
            else
                r_tmo <= '0;

            if (w_start_ok)
                r_err <= 1'b0;
            else if (w_state_nxt == ST_ERROR)
                r_err <= 1'b1;

            if (r_state == ST_IDLE && start_prog)
                r_done <= 1'b0;
            else if (r_state == ST_DONE)
                r_done <= 1'b1;
        end
    end

    assign upg_wen_o  = r_wen;
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign upg_done_o = r_done;
    assign cpu_rst_n  = r_done;
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Scoreboard bench for uart_prog_ctrl: expected writes are queued by stimulus, popped by a monitor.
module tb_uart_prog_ctrl;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst;
    logic              start_prog;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              upg_wen_o;
    logic [ADDR_W:0]   upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              cpu_rst_n;
    logic              busy;
    logic              err;

    logic [ADDR_W+32:0] exp_q[$];
    logic [ADDR_W+32:0] exp_w;
    int n_cmp = 0;
    int n_bad = 0;

    uart_prog_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(50)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_prog (start_prog),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && upg_wen_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got adr=%h dat=%h, required no write",
                         upg_adr_o, upg_dat_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({upg_adr_o, upg_dat_o} !== exp_w) begin
                    n_bad++;
                    $display("FAIL write: got adr=%h dat=%h, required adr=%h dat=%h",
                             upg_adr_o, upg_dat_o, exp_w[ADDR_W+32:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wen"},  upg_wen_o,  0);
        chk({tag, "_adr"},  upg_adr_o,  0);
        chk({tag, "_dat"},  upg_dat_o,  0);
        chk({tag, "_done"}, upg_done_o, 1);
        chk({tag, "_crn"},  cpu_rst_n,  1);
        chk({tag, "_busy"}, busy,       0);
        chk({tag, "_err"},  err,        0);
    endtask

    task automatic expect_wr(input logic [ADDR_W:0] adr, input logic [31:0] dat);
        exp_q.push_back({adr, dat});
    endtask

    // Bytes are listed left to right in transmit order; b2b sends on consecutive cycles.
    task automatic send(input logic [191:0] v, input int n, input bit b2b);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_byte  = v[8*(n-1-i) +: 8];
            if (!b2b) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
        end
        if (b2b) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_prog = 1'b1;
        @(posedge clk); #1 start_prog = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start_prog = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("reset_hold");
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_byte  = 8'($urandom_range(0, 255));
            @(posedge clk); #1 rx_valid = 1'b0;
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", upg_done_o, 1);

        // Start coincides with an 0xFF byte, which must not end the session.
        @(posedge clk); #1;
        start_prog = 1'b1; rx_valid = 1'b1; rx_byte = 8'hFF;
        @(posedge clk); #1;
        start_prog = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_done", upg_done_o, 0);
        chk("start_crn", cpu_rst_n, 0);
        expect_wr(15'h0000, 32'h00100513);
        expect_wr(15'h0001, 32'h00200593);
        send({8'h00, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00, 8'hFF}, 12, 1'b0);
        @(negedge clk);
        chk("done_state_busy", busy, 1);
        chk("done_state_done", upg_done_o, 0);
        @(negedge clk);
        chk("imem_done", upg_done_o, 1);
        chk("imem_crn", cpu_rst_n, 1);
        chk("imem_busy", busy, 0);

        pulse_start();
        expect_wr(15'h0000, 32'hDDCCBBAA);
        expect_wr(15'h4000, 32'h04030201);
        send({8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
              8'h01, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF}, 15, 1'b1);
        repeat (2) @(negedge clk);
        chk("dual_done", upg_done_o, 1);

        pulse_start();
        send({8'h05}, 1, 1'b0);
        @(negedge clk);
        chk("badtgt_err", err, 1);
        chk("badtgt_crn", cpu_rst_n, 0);
        chk("badtgt_busy", busy, 1);
        repeat (5) @(negedge clk);
        chk("badtgt_sticky", err, 1);
        pulse_start();
        @(negedge clk);
        chk("restart_err_clr", err, 0);
        expect_wr(15'h4000, 32'h12345678);
        send({8'h01, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF}, 8, 1'b0);
        repeat (2) @(negedge clk);
        chk("recover_done", upg_done_o, 1);
        chk("recover_err", err, 0);

        pulse_start();
        send({8'h00, 8'h01, 8'h40}, 3, 1'b0);
        @(negedge clk);
        chk("oversize_err", err, 1);

        pulse_start();
        send({8'h00, 8'h00, 8'h00, 8'hFF}, 4, 1'b0);
        repeat (2) @(negedge clk);
        chk("zerocnt_done", upg_done_o, 1);
        chk("zerocnt_err", err, 0);

        pulse_start();
        send({8'h00, 8'h01, 8'h00, 8'h11, 8'h22}, 5, 1'b0);
        repeat (45) @(negedge clk);
        chk("tmo_early_err", err, 0);
        chk("tmo_early_busy", busy, 1);
        repeat (10) @(negedge clk);
        chk("tmo_fire_err", err, 1);
        chk("tmo_fire_done", upg_done_o, 0);
        pulse_start();
        expect_wr(15'h0000, 32'hD4C3B2A1);
        send({8'h00, 8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hFF}, 8, 1'b0);
        repeat (2) @(negedge clk);
        chk("tmo_recover_done", upg_done_o, 1);

        pulse_start();
        send({8'h00, 8'h02, 8'h00, 8'h55, 8'h66}, 5, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid_hold");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid_after");
        send({8'h77, 8'h88, 8'h99, 8'hAA}, 4, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", upg_done_o, 1);

        chk("writes_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
